// File: rtl/ifu_fetch_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding imem requests and a
// 2-entry {pc,instr} FIFO feeding the IF/ID register, with EX-redirect flushing.
module ifu_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc_o,
  output logic [31:0] instr_o,
  output logic        ena_o,
  output logic        time_set_o,
  output logic        flush_o,
  output logic        flush_dly_o
);
  typedef enum logic [1:0] {FETCH, WAIT_RESP, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        started_q;
  logic [63:0] pc_q;
  logic [63:0] req_pc_q;
  logic [63:0] last_pc_q;
  logic [63:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;
  logic        popped_q;
  logic        req_fire, push, pop;

  // No response is ever owed in FETCH, so FIFO occupancy alone gates the request
  assign imem_req_valid = started_q && (state_q == FETCH) && (count_q != 2'd2);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state_q == WAIT_RESP) && imem_resp_valid && !redirect_valid;
  assign pop            = ena_o && !stall_i && !redirect_valid;

  assign ena_o   = (count_q != 2'd0);
  assign pc_o    = ena_o ? fifo_pc[rd_ptr_q] : last_pc_q;
  assign instr_o = ena_o ? fifo_instr[rd_ptr_q] : NOP_INSTR;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (req_fire)        state_d = WAIT_RESP;
      WAIT_RESP: if (imem_resp_valid) state_d = FETCH;
      DRAIN:     if (imem_resp_valid) state_d = FETCH;
      default:   state_d = FETCH;
    endcase
    // A redirect only needs DRAIN while a response is still owed after this edge
    if (redirect_valid) begin
      if (state_q == FETCH) state_d = req_fire ? DRAIN : FETCH;
      else                  state_d = imem_resp_valid ? FETCH : DRAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      started_q   <= 1'b0;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      last_pc_q   <= RESET_PC;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      popped_q    <= 1'b0;
      time_set_o  <= 1'b0;
      flush_o     <= 1'b0;
      flush_dly_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      started_q   <= 1'b1;
      flush_o     <= redirect_valid;
      flush_dly_o <= flush_o;
      time_set_o  <= pop && !popped_q;
      if (pop) popped_q <= 1'b1;
      if (req_fire) req_pc_q <= pc_q;
      if (redirect_valid) begin
        pc_q     <= redirect_pc;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (req_fire) pc_q <= pc_q + 64'd4;
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop) begin
          rd_ptr_q  <= ~rd_ptr_q;
          last_pc_q <= fifo_pc[rd_ptr_q];
        end
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= req_pc_q;
      fifo_instr[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Randomized bench for ifu_fetch_stage: a queue-level fetch model plus an imem
// responder, with directed scenarios pinned by literal expectations.
module tb_ifu_fetch_stage;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall_i, redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] pc_o;
  logic [31:0] instr_o;
  logic        ena_o, time_set_o, flush_o, flush_dly_o;

  always #5 clk = ~clk;

  ifu_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .stall_i(stall_i), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_o(pc_o), .instr_o(instr_o), .ena_o(ena_o),
    .time_set_o(time_set_o), .flush_o(flush_o), .flush_dly_o(flush_dly_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: delivered-instruction queue plus the one request that may be owed
  logic [95:0] m_q[$];
  logic [63:0] m_next_pc, m_last_pc, m_out_pc;
  logic        m_out, m_out_discard, m_started, m_first_popped;
  logic        m_time_set, m_flush, m_flush_dly;

  logic        mem_pending;
  logic [63:0] mem_addr;
  int          mem_cnt;

  logic [63:0] acc_q[$];
  int          ts_count, flush_count, watch_cycles, seen_cycles;
  logic        watch, seen;
  logic [63:0] seen_pc;

  function automatic logic [31:0] memData(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_next_pc = RESET_PC; m_last_pc = RESET_PC; m_out_pc = '0;
    m_out = 1'b0; m_out_discard = 1'b0; m_started = 1'b0; m_first_popped = 1'b0;
    m_time_set = 1'b0; m_flush = 1'b0; m_flush_dly = 1'b0;
    mem_pending = 1'b0; mem_cnt = 0; mem_addr = '0;
    ts_count = 0;
  endtask

  task automatic checkOutput();
    logic exp_rv;
    logic has;
    exp_rv = m_started && !m_out && (m_q.size() < 2);
    has    = (m_q.size() != 0);
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_next_pc);
    chk("ena_o", 64'(ena_o), 64'(has));
    chk("pc_o", pc_o, has ? m_q[0][95:32] : m_last_pc);
    chk("instr_o", 64'(instr_o), 64'(has ? m_q[0][31:0] : NOP));
    chk("time_set_o", 64'(time_set_o), 64'(m_time_set));
    chk("flush_o", 64'(flush_o), 64'(m_flush));
    chk("flush_dly_o", 64'(flush_dly_o), 64'(m_flush_dly));
    if (time_set_o) ts_count++;
    if (flush_o) flush_count++;
    if (watch) begin
      watch_cycles++;
      if (ena_o && !seen) begin
        seen = 1'b1; seen_pc = pc_o; seen_cycles = watch_cycles;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic stall, input logic ready,
                               input logic redir, input logic [63:0] target, input int lat);
    logic resp_v, fire_dut, fire, pop, exp_rv;
    logic [31:0] data;
    @(negedge clk);
    checkOutput();
    rst_n = rst_v;
    if (!rst_v) begin
      stall_i = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; imem_resp_valid = 1'b0;
      modelReset();
      return;
    end
    stall_i = stall; imem_req_ready = ready; redirect_valid = redir; redirect_pc = target;
    resp_v = mem_pending && (mem_cnt == 0);
    data   = resp_v ? memData(mem_addr) : 32'($urandom);
    imem_resp_valid = resp_v; imem_resp_data = data;
    fire_dut = imem_req_valid && ready;
    if (resp_v) mem_pending = 1'b0;
    else if (mem_pending) mem_cnt--;
    if (fire_dut) begin
      mem_pending = 1'b1; mem_addr = imem_req_addr; mem_cnt = lat - 1;
      acc_q.push_back(imem_req_addr);
    end
    // Model advance across the coming edge
    exp_rv = m_started && !m_out && (m_q.size() < 2);
    fire   = exp_rv && ready;
    pop    = (m_q.size() != 0) && !stall && !redir;
    m_time_set = pop && !m_first_popped;
    if (pop) begin
      m_first_popped = 1'b1;
      m_last_pc = m_q[0][95:32];
      void'(m_q.pop_front());
    end
    if (resp_v) begin
      if (!redir && !m_out_discard) m_q.push_back({m_out_pc, data});
      m_out = 1'b0;
    end
    if (fire) begin
      m_out = 1'b1; m_out_pc = m_next_pc; m_out_discard = 1'b0; m_next_pc = m_next_pc + 64'd4;
    end
    if (redir) begin
      m_q.delete(); m_next_pc = target;
      if (m_out) m_out_discard = 1'b1;
    end
    m_flush_dly = m_flush; m_flush = redir; m_started = 1'b1;
  endtask

  task automatic armWatch();
    watch = 1'b1; seen = 1'b0; watch_cycles = 0; seen_cycles = 0; seen_pc = '0;
  endtask

  task automatic randomCycle();
    logic s, r, d;
    logic [63:0] tgt;
    s = ($urandom_range(0, 99) < 30);
    r = ($urandom_range(0, 99) < 70);
    d = ($urandom_range(0, 99) < 5);
    if ($urandom_range(0, 9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
    else tgt = {32'h0, 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2)};
    applyStimulus(1'b1, s, r, d, tgt, $urandom_range(1, 3));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    rst_n = 1'b1; stall_i = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_resp_valid = 1'b0; imem_resp_data = '0; watch = 1'b0;
    flush_count = 0;
    modelReset();
    #1 rst_n = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1);

    // Reset release, ready=1, 1-cycle latency
    acc_q.delete(); armWatch();
    repeat (14) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);
    chk("t1_acc_count", 64'(acc_q.size() >= 3), 64'd1);
    if (acc_q.size() >= 3) begin
      chk("t1_addr0", acc_q[0], 64'h8000_0000);
      chk("t1_addr1", acc_q[1], 64'h8000_0004);
      chk("t1_addr2", acc_q[2], 64'h8000_0008);
    end
    chk("t1_first_pc", seen_pc, 64'h8000_0000);
    chk("t1_time_set_pulses", 64'(ts_count), 64'd1);

    // Stall for 5 cycles: FIFO fills and requests stop
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
    @(posedge clk); #1;
    chk("t2_full_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t2_full_ena", 64'(ena_o), 64'd1);
    chk("t2_model_depth", 64'(m_q.size()), 64'd2);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);

    // Redirect while a request is in flight
    n = 0;
    while (!(mem_pending && mem_cnt >= 1) && n < 20) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 3); n++;
    end
    chk("t3_inflight_found", 64'(mem_pending && mem_cnt >= 1), 64'd1);
    flush_count = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 64'h8000_0100, 3);
    armWatch();
    repeat (14) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);
    chk("t3_seen", 64'(seen), 64'd1);
    chk("t3_first_pc", seen_pc, 64'h8000_0100);
    chk("t3_latency_ge3", 64'(seen_cycles >= 3), 64'd1);
    chk("t3_flush_cycles", 64'(flush_count), 64'd1);

    // Redirect in the same cycle as a response
    n = 0;
    while (!(mem_pending && mem_cnt == 0) && n < 20) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 2); n++;
    end
    chk("t4_resp_aligned", 64'(mem_pending && mem_cnt == 0), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0180, 2);
    @(posedge clk); #1;
    chk("t4_ena_after", 64'(ena_o), 64'd0);
    chk("t4_instr_nop", 64'(instr_o), 64'h0000_0013);
    armWatch();
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);
    chk("t4_first_pc", seen_pc, 64'h8000_0180);

    // Request held for 4 cycles while not ready
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0400, 1);
    n = 0;
    while (!imem_req_valid && n < 10) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1); n++;
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1);
      chk("t5_req_valid", 64'(imem_req_valid), 64'd1);
      chk("t5_req_addr", imem_req_addr, 64'h8000_0400);
    end
    acc_q.delete();
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1);
    chk("t5_first_acc", acc_q.size() != 0 ? acc_q[0] : '1, 64'h8000_0400);
    chk("t5_head_pc", pc_o, 64'h8000_0400);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);

    // Back-to-back redirects: last target wins
    flush_count = 0; acc_q.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0200, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0300, 1);
    armWatch();
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);
    chk("t6_first_acc", acc_q.size() != 0 ? acc_q[0] : '1, 64'h8000_0300);
    chk("t6_first_pc", seen_pc, 64'h8000_0300);
    chk("t6_flush_cycles", 64'(flush_count), 64'd2);

    // PC wraps modulo 2^64
    acc_q.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1);
    chk("wrap_count", 64'(acc_q.size() >= 2), 64'd1);
    if (acc_q.size() >= 2) begin
      chk("wrap_addr0", acc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_addr1", acc_q[1], 64'h0);
    end

    watch = 1'b0;
    repeat (1500) randomCycle();

    // Reset asserted while a request is outstanding
    n = 0;
    while (!mem_pending && n < 20) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 3); n++;
    end
    chk("rst_inflight_found", 64'(mem_pending), 64'd1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1);
    @(posedge clk); #1;
    chk("rst_pc_o", pc_o, 64'h8000_0000);
    chk("rst_instr_o", 64'(instr_o), 64'h0000_0013);
    chk("rst_ena_o", 64'(ena_o), 64'd0);
    repeat (1000) randomCycle();
    chk("rst_time_set_pulses", 64'(ts_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
